mm_con_hs: RTL and testbench
============================

# mm_con_hs

Parametrised memory-mapped interconnect between one bus master (the SPI slave front end) and `NUM_SLAVES` register slaves, with a request/acknowledge handshake. It replaces the fixed five-slave combinational decoder. Each transaction is decoded on fixed power-of-two address windows. Slaves may stretch an access by delaying their acknowledge. A timeout and error counter keep a dead or missing slave from hanging the master.

## Interface
Parameters:
- `MM_ADDR_WIDTH`, 8: master/slave address width.
- `MM_DATA_WIDTH`, 16: data width.
- `NUM_SLAVES`, 5: number of slave ports, 1..2^(MM_ADDR_WIDTH-SLV_WIN_BITS).
- `SLV_WIN_BITS`, 4: log2 of each slave window in address units. Slave index = `addr[MM_ADDR_WIDTH-1:SLV_WIN_BITS]`.
- `TIMEOUT_CYCLES`, 16: maximum cycles `s_sel_o` is held waiting for `s_ack_i`, ≥2.
- `ERR_CNT_WIDTH`, 8: width of the saturating error counter.

Ports:
- `clk_sys_i` in 1: system clock. One clock; reset is synchronous and active-high.
- `rst_i` in 1: synchronous active-high reset.
- `m_addr_i` in MM_ADDR_WIDTH: master address, sampled with `m_req_i`.
- `m_wdata_i` in MM_DATA_WIDTH: master write data, sampled with `m_req_i`.
- `m_we_i` in 1: 1 = write, 0 = read, sampled with `m_req_i`.
- `m_req_i` in 1: start of transaction. Sampled only in IDLE.
- `m_rdata_o` out MM_DATA_WIDTH: read data. Valid when `m_ack_o` is high and held until the next ack.
- `m_ack_o` out 1: one-cycle transaction-complete pulse.
- `m_err_o` out 1: qualifies `m_ack_o`. Indicates a decode error or timeout.
- `m_busy_o` out 1: high while not IDLE.
- `m_err_cnt_o` out ERR_CNT_WIDTH: saturating count of errored transactions.
- `s_addr_o` out MM_ADDR_WIDTH: latched full address, broadcast to all slaves.
- `s_wdata_o` out MM_DATA_WIDTH: latched write data, broadcast.
- `s_we_o` out 1: write strobe. High with `s_sel_o` for writes only.
- `s_sel_o` out NUM_SLAVES: one-hot slave select.
- `s_rdata_i` in NUM_SLAVES*MM_DATA_WIDTH: packed read data. Slave k occupies bits `[k*W +: W]`.
- `s_ack_i` in NUM_SLAVES: per-slave acknowledge.

## Operation
- FSM states are IDLE and ACCESS. All outputs are registered.
- IDLE, `m_req_i`=1:
  - Latch addr, wdata and we; compute idx.
  - If idx ≥ NUM_SLAVES: stay IDLE and next cycle emit `m_ack_o`=1, `m_err_o`=1, `m_rdata_o`=0, and increment the error counter.
  - Otherwise: go to ACCESS, set `s_sel_o[idx]`=1, set `s_we_o`=we, clear the timer.
- ACCESS:
  - Only `s_ack_i[idx]` is honoured. Acks from unselected slaves are ignored.
  - On ack: clear sel and we, return to IDLE, and next cycle emit `m_ack_o`=1 with `m_err_o`=0.
  - `m_rdata_o` takes `s_rdata_i[idx]` for a read. For a write it keeps its previous value.
  - Otherwise the timer increments. When it reaches TIMEOUT_CYCLES-1 without an ack: clear sel, return to IDLE, and emit `m_ack_o`=1, `m_err_o`=1, `m_rdata_o`=0, incrementing the error counter.
- If an ack arrives on the final timeout cycle, the ack wins and no error is flagged.
- `m_req_i` while busy is ignored and not queued.
- A new request in the same cycle `m_ack_o` is high is accepted (back-to-back).
- The error counter saturates at all-ones. It is cleared only by reset.

## Timing
- Reset: state IDLE. All outputs are 0, including `m_rdata_o`, `m_err_cnt_o`, `s_sel_o`, `s_addr_o` and `s_wdata_o`.
- Reset mid-ACCESS drops select next edge with no ack. A late slave ack after reset is ignored.
- Request at cycle N:
  - Decode error: ack at N+1.
  - Valid slave: `s_sel_o` is high from N+1. A slave ack sampled at cycle K gives `m_ack_o` at K+1. The minimum, with the slave acking at N+1, is ack at N+2.
  - Timeout: sel is high for cycles N+1..N+TIMEOUT_CYCLES; the error ack comes at N+TIMEOUT_CYCLES+1.
- `s_addr_o`, `s_wdata_o` and `s_we_o` are stable for the whole time sel is high.

## Structure
- Package `mm_con_pkg` holds:
  - the state enum (IDLE, ACCESS);
  - the index-width function `clog2`;
  - the error read-data constant (0).
- Sub-module `mm_con_tmo` is the timeout counter. It has clear, enable and expire outputs and a width derived from TIMEOUT_CYCLES.
- The read-data mux is an indexed part-select on the latched idx. No per-address case list is used.

## Test plan
- Write to slave 3 (addr 0x30, data 0xA5A5), with the slave acking 2 cycles after sel. Required: `s_sel_o`=0b01000 and `s_we_o`=1 for exactly 2 cycles, then `m_ack_o` 1 cycle with err=0; the counter stays 0.
- Read slave 1 (addr 0x14), with the slave driving 0x1234 and acking on its first select cycle. Required: `m_ack_o` at N+2 with `m_rdata_o`=0x1234, and `s_we_o` never asserted.
- Read addr 0x70 with NUM_SLAVES=5. Required: no sel, ack+err at N+1, rdata 0, `m_err_cnt_o`=1.
- Read slave 0 with no ack, TIMEOUT_CYCLES=16. Required: sel high for 16 cycles, ack+err at N+17, rdata 0. In a second run, an ack on cycle 16 produces a normal ack with no error.
- Ack from slave 2 while slave 4 is selected, then a request pulsed mid-ACCESS. Both are ignored; only slave 4's ack completes. Then issue a back-to-back request in the ack cycle and check it is accepted.
- Assert `rst_i` mid-ACCESS. Required: sel is 0 next cycle, no ack is ever emitted, all outputs are 0. Also force 300 decode errors with ERR_CNT_WIDTH=8 and check the counter saturates at 255.

Source files
------------

// File: rtl/mm_con_pkg.sv
// Shared types and helpers for the mm_con_hs interconnect.
package mm_con_pkg;

    // Transaction FSM: waiting for a master request, or holding a slave selected.
    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    // Read data returned to the master on a decode error or timeout.
    localparam int unsigned ERR_RDATA = 0;

    // Ceiling log2 with a minimum of 1, used to size indices and counters.
    function automatic int clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/mm_con_tmo.sv
// Timeout counter: counts cycles spent waiting for a slave acknowledge and
// flags the last permitted cycle.
module mm_con_tmo
    import mm_con_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_sys_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CNT_W = clog2(TIMEOUT_CYCLES);
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t CNT_LAST = cnt_t'(TIMEOUT_CYCLES - 1);

    cnt_t cnt_q;

    // Count waiting cycles; cleared on reset and at the start of each access.
    always_ff @(posedge clk_sys_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst_i || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The access is abandoned at the edge that ends cycle TIMEOUT_CYCLES.
    assign expire = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/mm_con_hs.sv
// Memory-mapped interconnect: one master, NUM_SLAVES register slaves on fixed
// power-of-two windows, request/acknowledge handshake with timeout and a
// saturating error counter. All outputs are registered.
module mm_con_hs
    import mm_con_pkg::*;
#(
    parameter int MM_ADDR_WIDTH  = 8,
    parameter int MM_DATA_WIDTH  = 16,
    parameter int NUM_SLAVES     = 5,
    parameter int SLV_WIN_BITS   = 4,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ERR_CNT_WIDTH  = 8
) (
    input  logic                                clk_sys_i,
    input  logic                                rst_i,
    input  logic [MM_ADDR_WIDTH-1:0]            m_addr_i,
    input  logic [MM_DATA_WIDTH-1:0]            m_wdata_i,
    input  logic                                m_we_i,
    input  logic                                m_req_i,
    output logic [MM_DATA_WIDTH-1:0]            m_rdata_o,
    output logic                                m_ack_o,
    output logic                                m_err_o,
    output logic                                m_busy_o,
    output logic [ERR_CNT_WIDTH-1:0]            m_err_cnt_o,
    output logic [MM_ADDR_WIDTH-1:0]            s_addr_o,
    output logic [MM_DATA_WIDTH-1:0]            s_wdata_o,
    output logic                                s_we_o,
    output logic [NUM_SLAVES-1:0]               s_sel_o,
    input  logic [NUM_SLAVES*MM_DATA_WIDTH-1:0] s_rdata_i,
    input  logic [NUM_SLAVES-1:0]               s_ack_i
);

    localparam int IDX_W = MM_ADDR_WIDTH - SLV_WIN_BITS;
    typedef logic [IDX_W:0]        idx_ext_t;
    typedef logic [NUM_SLAVES-1:0] sel_t;
    localparam idx_ext_t NUM_SLAVES_EXT = idx_ext_t'(NUM_SLAVES);

    state_t                     state_q;
    state_t                     state_d;
    logic [MM_DATA_WIDTH-1:0]   rdata_d;
    logic                       ack_d;
    logic                       err_d;
    logic                       busy_d;
    logic [ERR_CNT_WIDTH-1:0]   err_cnt_d;
    logic [MM_ADDR_WIDTH-1:0]   addr_d;
    logic [MM_DATA_WIDTH-1:0]   wdata_d;
    logic                       we_d;
    sel_t                       sel_d;

    logic [IDX_W-1:0]           idx_req;
    logic [IDX_W-1:0]           idx_q;
    logic                       req_valid;
    sel_t                       req_onehot;
    logic                       ack_hit;
    logic [MM_DATA_WIDTH-1:0]   slv_rdata;
    logic                       tmo_clr;
    logic                       tmo_en;
    logic                       tmo_expire;
    logic                       err_inc;

    // Decode of the incoming request and of the transaction in flight.
    assign idx_req    = m_addr_i[MM_ADDR_WIDTH-1:SLV_WIN_BITS];
    assign req_valid  = {1'b0, idx_req} < NUM_SLAVES_EXT;
    assign req_onehot = sel_t'(1) << idx_req;
    assign idx_q      = s_addr_o[MM_ADDR_WIDTH-1:SLV_WIN_BITS];
    // Only the selected slave's ack counts; others are masked by the select.
    assign ack_hit    = |(s_ack_i & s_sel_o);
    assign slv_rdata  = s_rdata_i[int'(idx_q)*MM_DATA_WIDTH +: MM_DATA_WIDTH];

    mm_con_tmo #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo (
        .clk_sys_i (clk_sys_i),
        .rst_i     (rst_i),
        .clr       (tmo_clr),
        .en        (tmo_en),
        .expire    (tmo_expire)
    );

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        rdata_d   = m_rdata_o;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        addr_d    = s_addr_o;
        wdata_d   = s_wdata_o;
        we_d      = s_we_o;
        sel_d     = s_sel_o;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        err_inc   = 1'b0;
        err_cnt_d = m_err_cnt_o;

        unique case (state_q)
            S_IDLE: begin
                if (m_req_i) begin
                    addr_d  = m_addr_i;
                    wdata_d = m_wdata_i;
                    if (req_valid) begin
                        state_d = S_ACCESS;
                        sel_d   = req_onehot;
                        we_d    = m_we_i;
                        tmo_clr = 1'b1;
                    end else begin
                        ack_d   = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = MM_DATA_WIDTH'(ERR_RDATA);
                        err_inc = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                tmo_en = 1'b1;
                // An ack on the final timeout cycle still wins.
                if (ack_hit) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    if (!s_we_o) begin
                        rdata_d = slv_rdata;
                    end
                end else if (tmo_expire) begin
                    state_d = S_IDLE;
                    sel_d   = '0;
                    we_d    = 1'b0;
                    ack_d   = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = MM_DATA_WIDTH'(ERR_RDATA);
                    err_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (err_inc && (m_err_cnt_o != '1)) begin
            err_cnt_d = m_err_cnt_o + 1'b1;
        end

        busy_d = (state_d == S_ACCESS);
    end

    // State and registered outputs, all cleared by synchronous reset.
    always_ff @(posedge clk_sys_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            m_rdata_o   <= '0;
            m_ack_o     <= 1'b0;
            m_err_o     <= 1'b0;
            m_busy_o    <= 1'b0;
            m_err_cnt_o <= '0;
            s_addr_o    <= '0;
            s_wdata_o   <= '0;
            s_we_o      <= 1'b0;
            s_sel_o     <= '0;
        end else begin
            state_q     <= state_d;
            m_rdata_o   <= rdata_d;
            m_ack_o     <= ack_d;
            m_err_o     <= err_d;
            m_busy_o    <= busy_d;
            m_err_cnt_o <= err_cnt_d;
            s_addr_o    <= addr_d;
            s_wdata_o   <= wdata_d;
            s_we_o      <= we_d;
            s_sel_o     <= sel_d;
        end
    end

endmodule

// File: tb/tb_mm_con_hs.sv
// Self-checking bench for mm_con_hs: directed scenarios plus randomized
// transactions, each predicted from the address map and slave ack timing.
module tb_mm_con_hs;

    localparam int AW  = 8;
    localparam int DW  = 16;
    localparam int NS  = 5;
    localparam int WIN = 4;
    localparam int TMO = 16;
    localparam int EW  = 8;

    logic              clk_sys_i = 1'b0;
    logic              rst_i;
    logic [AW-1:0]     m_addr_i;
    logic [DW-1:0]     m_wdata_i;
    logic              m_we_i;
    logic              m_req_i;
    logic [DW-1:0]     m_rdata_o;
    logic              m_ack_o;
    logic              m_err_o;
    logic              m_busy_o;
    logic [EW-1:0]     m_err_cnt_o;
    logic [AW-1:0]     s_addr_o;
    logic [DW-1:0]     s_wdata_o;
    logic              s_we_o;
    logic [NS-1:0]     s_sel_o;
    logic [NS*DW-1:0]  s_rdata_i;
    logic [NS-1:0]     s_ack_i;

    int          tests = 0;
    int          fails = 0;
    logic [15:0] rdata_model;
    int          errcnt_model;

    always #5 clk_sys_i = ~clk_sys_i;

    mm_con_hs #(
        .MM_ADDR_WIDTH  (AW),
        .MM_DATA_WIDTH  (DW),
        .NUM_SLAVES     (NS),
        .SLV_WIN_BITS   (WIN),
        .TIMEOUT_CYCLES (TMO),
        .ERR_CNT_WIDTH  (EW)
    ) dut (
        .clk_sys_i   (clk_sys_i),
        .rst_i       (rst_i),
        .m_addr_i    (m_addr_i),
        .m_wdata_i   (m_wdata_i),
        .m_we_i      (m_we_i),
        .m_req_i     (m_req_i),
        .m_rdata_o   (m_rdata_o),
        .m_ack_o     (m_ack_o),
        .m_err_o     (m_err_o),
        .m_busy_o    (m_busy_o),
        .m_err_cnt_o (m_err_cnt_o),
        .s_addr_o    (s_addr_o),
        .s_wdata_o   (s_wdata_o),
        .s_we_o      (s_we_o),
        .s_sel_o     (s_sel_o),
        .s_rdata_i   (s_rdata_i),
        .s_ack_i     (s_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Outputs of an idle interconnect between transactions.
    task automatic check_idle(input string tag);
        chk({tag, " sel"},    32'(s_sel_o), 32'd0);
        chk({tag, " we"},     32'(s_we_o), 32'd0);
        chk({tag, " ack"},    32'(m_ack_o), 32'd0);
        chk({tag, " busy"},   32'(m_busy_o), 32'd0);
        chk({tag, " rdata"},  32'(m_rdata_o), 32'(rdata_model));
        chk({tag, " errcnt"}, 32'(m_err_cnt_o), 32'(errcnt_model));
    endtask

    // One master transaction. Called at a falling edge; returns at the falling
    // edge of the ack cycle so the next call issues a back-to-back request.
    // d = select cycle in which the addressed slave acks (0 = never).
    task automatic do_txn(input logic [7:0] addr, input logic [15:0] wdata, input logic we,
                          input int d, input logic [15:0] sdata, input int gap, input bit noise);
        int            idx;
        int            len;
        bit            ok;
        bit            acked;
        bit            err;
        logic [NS-1:0] oh;
        logic [79:0]   rd;
        for (int g = 0; g < gap; g++) begin
            @(negedge clk_sys_i);
            check_idle("gap");
        end
        idx   = int'(addr) / (1 << WIN);
        ok    = idx < NS;
        acked = (d >= 1) && (d <= TMO);
        len   = acked ? d : TMO;
        oh    = ok ? (NS'(1) << idx) : '0;
        rd    = {$urandom, $urandom, $urandom};
        if (ok) rd[idx*DW +: DW] = sdata;
        s_rdata_i = rd;
        m_addr_i  = addr;
        m_wdata_i = wdata;
        m_we_i    = we;
        m_req_i   = 1'b1;
        if (ok) begin
            for (int c = 1; c <= len; c++) begin
                @(negedge clk_sys_i);
                chk("acc sel",    32'(s_sel_o), 32'(oh));
                chk("acc we",     32'(s_we_o), 32'(we));
                chk("acc addr",   32'(s_addr_o), 32'(addr));
                chk("acc wdata",  32'(s_wdata_o), 32'(wdata));
                chk("acc ack",    32'(m_ack_o), 32'd0);
                chk("acc busy",   32'(m_busy_o), 32'd1);
                chk("acc rdata",  32'(m_rdata_o), 32'(rdata_model));
                chk("acc errcnt", 32'(m_err_cnt_o), 32'(errcnt_model));
                s_ack_i = (c == d) ? oh : '0;
                m_req_i = 1'b0;
                if (noise) begin
                    s_ack_i = s_ack_i | (NS'($urandom) & ~oh);
                    if ($urandom_range(0, 2) == 0) begin
                        m_req_i   = 1'b1;
                        m_addr_i  = {4'($urandom_range(0, NS - 1)), 4'($urandom)};
                        m_wdata_i = 16'($urandom);
                        m_we_i    = 1'($urandom);
                    end
                end
            end
        end
        @(negedge clk_sys_i);
        s_ack_i = '0;
        m_req_i = 1'b0;
        err = !ok || !acked;
        if (err) begin
            rdata_model = 16'h0;
            if (errcnt_model < 255) errcnt_model++;
        end else if (!we) begin
            rdata_model = sdata;
        end
        chk("done ack",    32'(m_ack_o), 32'd1);
        chk("done err",    32'(m_err_o), 32'(err));
        chk("done sel",    32'(s_sel_o), 32'd0);
        chk("done we",     32'(s_we_o), 32'd0);
        chk("done busy",   32'(m_busy_o), 32'd0);
        chk("done rdata",  32'(m_rdata_o), 32'(rdata_model));
        chk("done errcnt", 32'(m_err_cnt_o), 32'(errcnt_model));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " rdata"},  32'(m_rdata_o), 32'd0);
        chk({tag, " ack"},    32'(m_ack_o), 32'd0);
        chk({tag, " err"},    32'(m_err_o), 32'd0);
        chk({tag, " busy"},   32'(m_busy_o), 32'd0);
        chk({tag, " errcnt"}, 32'(m_err_cnt_o), 32'd0);
        chk({tag, " saddr"},  32'(s_addr_o), 32'd0);
        chk({tag, " swdata"}, 32'(s_wdata_o), 32'd0);
        chk({tag, " swe"},    32'(s_we_o), 32'd0);
        chk({tag, " sel"},    32'(s_sel_o), 32'd0);
    endtask

    initial begin
        rdata_model  = 16'h0;
        errcnt_model = 0;
        rst_i     = 1'b1;
        m_addr_i  = 8'h0;
        m_wdata_i = 16'h0;
        m_we_i    = 1'b0;
        m_req_i   = 1'b0;
        s_rdata_i = '0;
        s_ack_i   = '0;

        // Reset state.
        repeat (3) @(negedge clk_sys_i);
        check_all_zero("reset");
        rst_i = 1'b0;
        @(negedge clk_sys_i);

        // Read slave 1, acked on the first select cycle: ack at N+2.
        do_txn(8'h14, 16'h0, 1'b0, 1, 16'h1234, 0, 1'b0);
        // Write slave 3, acked on the second select cycle; rdata held.
        do_txn(8'h30, 16'hA5A5, 1'b1, 2, 16'hBEEF, 1, 1'b0);
        chk("write errcnt", 32'(m_err_cnt_o), 32'd0);
        // Decode error: window 7 does not exist.
        do_txn(8'h70, 16'h0, 1'b0, 1, 16'h0, 1, 1'b0);
        chk("decode errcnt", 32'(m_err_cnt_o), 32'd1);
        // Slave 0 never acks: timeout after 16 select cycles.
        do_txn(8'h03, 16'h0, 1'b0, 0, 16'h5555, 1, 1'b0);
        // Slave 0 acks on the final timeout cycle: the ack wins.
        do_txn(8'h05, 16'h0, 1'b0, TMO, 16'h6666, 1, 1'b0);
        // Slave 4 with stray acks from other slaves and requests mid-access.
        do_txn(8'h4C, 16'h0, 1'b0, 6, 16'h4444, 1, 1'b1);
        // Back-to-back request issued in the ack cycle.
        do_txn(8'h2A, 16'h0, 1'b0, 1, 16'h2222, 0, 1'b0);
        do_txn(8'h1F, 16'h7777, 1'b1, 3, 16'h0, 0, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 80; i++) begin
            logic [7:0] a;
            int         dly;
            a   = {4'($urandom_range(0, 6)), 4'($urandom)};
            dly = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TMO + 3) : $urandom_range(1, 4);
            do_txn(a, 16'($urandom), 1'($urandom), dly, 16'($urandom),
                   $urandom_range(0, 2), 1'($urandom));
        end

        // Error counter saturation with 300 decode errors.
        for (int i = 0; i < 300; i++) begin
            do_txn({4'($urandom_range(NS, 15)), 4'($urandom)}, 16'h0, 1'b0, 1, 16'h0, 0, 1'b0);
        end
        chk("saturated errcnt", 32'(m_err_cnt_o), 32'd255);

        // Reset mid-access: select drops, late acks are ignored.
        @(negedge clk_sys_i);
        m_addr_i = 8'h20;
        m_we_i   = 1'b0;
        m_req_i  = 1'b1;
        @(negedge clk_sys_i);
        m_req_i = 1'b0;
        chk("pre-reset sel", 32'(s_sel_o), 32'b00100);
        rst_i = 1'b1;
        @(negedge clk_sys_i);
        check_all_zero("mid reset");
        rst_i   = 1'b0;
        s_ack_i = '1;
        rdata_model  = 16'h0;
        errcnt_model = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_sys_i);
            check_all_zero("late ack");
        end
        s_ack_i = '0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
